// File: rtl/vga_sync_rx.sv
// Receive-side VGA timing decoder: recovers pixel position from hsync/vsync,
// validates line/frame lengths, and produces lock and display-enable.
module vga_sync_rx #(
   parameter int unsigned H_TOTAL     = 800,
   parameter int unsigned V_TOTAL     = 525,
   parameter int unsigned H_ACT_START = 144,
   parameter int unsigned H_ACT_LEN   = 640,
   parameter int unsigned V_ACT_START = 35,
   parameter int unsigned V_ACT_LEN   = 480,
   parameter int unsigned LOCK_FRAMES = 2,
   parameter int unsigned CNT_BIT     = 10
) (
   input  logic               clk,
   input  logic               i_sclr,
   input  logic               i_px_clk,
   input  logic               i_vga_hsync,
   input  logic               i_vga_vsync,
   output logic [CNT_BIT-1:0] o_x,
   output logic [CNT_BIT-1:0] o_y,
   output logic               o_de,
   output logic               o_frame_start,
   output logic               o_locked,
   output logic               o_err
);

   localparam int unsigned GOOD_W = $clog2(LOCK_FRAMES + 1);

   localparam logic [CNT_BIT-1:0] H_MAX  = CNT_BIT'(H_TOTAL);
   localparam logic [CNT_BIT-1:0] H_LAST = CNT_BIT'(H_TOTAL - 1);
   localparam logic [CNT_BIT-1:0] V_MAX  = CNT_BIT'(V_TOTAL);
   localparam logic [CNT_BIT-1:0] V_LAST = CNT_BIT'(V_TOTAL - 1);
   localparam logic [CNT_BIT-1:0] H_AS   = CNT_BIT'(H_ACT_START);
   localparam logic [CNT_BIT-1:0] H_AE   = CNT_BIT'(H_ACT_START + H_ACT_LEN);
   localparam logic [CNT_BIT-1:0] V_AS   = CNT_BIT'(V_ACT_START);
   localparam logic [CNT_BIT-1:0] V_AE   = CNT_BIT'(V_ACT_START + V_ACT_LEN);
   localparam logic [GOOD_W-1:0]  GOOD_LAST = GOOD_W'(LOCK_FRAMES - 1);

   typedef enum logic [1:0] {SEEK, CHECK, LOCKED} state_t;

   state_t              state, state_next;
   logic [GOOD_W-1:0]   good_cnt, good_next;
   logic                hs_prev, vs_prev;
   logic [CNT_BIT-1:0]  h_cnt, v_cnt, h_next, v_next;
   logic                h_rise, v_rise, viol, err_next, de_next;

   assign h_rise = i_vga_hsync & ~hs_prev;
   assign v_rise = i_vga_vsync & ~vs_prev;

   always_comb begin
      h_next = h_cnt;
      v_next = v_cnt;
      if (h_rise)
         h_next = '0;
      else if (h_cnt != H_MAX)
         h_next = h_cnt + 1'b1;
      if (v_rise)
         v_next = '0;
      else if (h_rise && (v_cnt != V_MAX))
         v_next = v_cnt + 1'b1;
   end

   // Early line/frame ends are caught at the sync edge; missing syncs are
   // caught once, on the step where the counter reaches its total.
   assign viol = ( h_rise && (h_cnt != H_LAST))
              || (!h_rise && (h_cnt == H_LAST))
              || ( v_rise && (v_cnt != V_LAST))
              || (!v_rise && h_rise && (v_cnt == V_LAST));

   always_comb begin
      state_next = state;
      good_next  = good_cnt;
      err_next   = 1'b0;
      if (i_px_clk) begin
         case (state)
            SEEK: begin
               if (v_rise) begin
                  state_next = CHECK;
                  good_next  = '0;
               end
            end
            CHECK, LOCKED: begin
               if (viol) begin
                  err_next  = 1'b1;
                  good_next = '0;
                  // A failing vsync edge is still a valid frame start.
                  state_next = v_rise ? CHECK : SEEK;
               end else if (v_rise && (state == CHECK)) begin
                  if (good_cnt == GOOD_LAST)
                     state_next = LOCKED;
                  else
                     good_next = good_cnt + 1'b1;
               end
            end
            default: state_next = SEEK;
         endcase
      end
   end

   assign de_next = (state_next == LOCKED)
                 && (h_next >= H_AS) && (h_next < H_AE)
                 && (v_next >= V_AS) && (v_next < V_AE);

   always_ff @(posedge clk or posedge i_sclr) begin
      if (i_sclr) begin
         state    <= SEEK;
         good_cnt <= '0;
         o_locked <= 1'b0;
      end else begin
         state    <= state_next;
         good_cnt <= good_next;
         o_locked <= (state_next == LOCKED);
      end
   end

   always_ff @(posedge clk or posedge i_sclr) begin
      if (i_sclr) begin
         hs_prev       <= 1'b0;
         vs_prev       <= 1'b0;
         h_cnt         <= '0;
         v_cnt         <= '0;
         o_de          <= 1'b0;
         o_x           <= '0;
         o_y           <= '0;
         o_err         <= 1'b0;
         o_frame_start <= 1'b0;
      end else begin
         o_err         <= err_next;
         o_frame_start <= i_px_clk & v_rise;
         if (i_px_clk) begin
            hs_prev <= i_vga_hsync;
            vs_prev <= i_vga_vsync;
            h_cnt   <= h_next;
            v_cnt   <= v_next;
            o_de    <= de_next;
            o_x     <= de_next ? (h_next - H_AS) : '0;
            o_y     <= de_next ? (v_next - V_AS) : '0;
         end
      end
   end

endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx on a scaled-down raster; expected outputs come from a
// line/frame-level model of the lock rules driven by the stream generator.
module tb_vga_sync_rx;

   localparam int HT  = 24;
   localparam int VT  = 14;
   localparam int HAS = 5;
   localparam int HAL = 16;
   localparam int VAS = 3;
   localparam int VAL = 9;
   localparam int LF  = 2;
   localparam int CB  = 10;
   localparam int HSW = 2;
   localparam int VSW = 2;

   logic          clk = 1'b0;
   logic          i_sclr, i_px_clk, i_vga_hsync, i_vga_vsync;
   logic [CB-1:0] o_x, o_y;
   logic          o_de, o_frame_start, o_locked, o_err;

   always #5 clk = ~clk;

   vga_sync_rx #(
      .H_TOTAL(HT), .V_TOTAL(VT), .H_ACT_START(HAS), .H_ACT_LEN(HAL),
      .V_ACT_START(VAS), .V_ACT_LEN(VAL), .LOCK_FRAMES(LF), .CNT_BIT(CB)
   ) dut (
      .clk(clk), .i_sclr(i_sclr), .i_px_clk(i_px_clk),
      .i_vga_hsync(i_vga_hsync), .i_vga_vsync(i_vga_vsync),
      .o_x(o_x), .o_y(o_y), .o_de(o_de), .o_frame_start(o_frame_start),
      .o_locked(o_locked), .o_err(o_err)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // reference model state
   int            k, lidx, good;
   bit            armed, locked;
   logic          exp_de, exp_err, exp_fs, exp_locked;
   logic [CB-1:0] exp_x, exp_y;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all();
      chk("o_err",         32'(o_err),         32'(exp_err));
      chk("o_frame_start", 32'(o_frame_start), 32'(exp_fs));
      chk("o_locked",      32'(o_locked),      32'(exp_locked));
      chk("o_de",          32'(o_de),          32'(exp_de));
      chk("o_x",           32'(o_x),           32'(exp_x));
      chk("o_y",           32'(o_y),           32'(exp_y));
   endtask

   task automatic model_reset();
      k = 0; lidx = 0; good = 0; armed = 0; locked = 0;
      exp_de = 0; exp_err = 0; exp_fs = 0; exp_locked = 0; exp_x = '0; exp_y = '0;
   endtask

   // One pixel of line l, position p; present=0 means the line's hsync is suppressed.
   task automatic pixel(input int l, input int p, input bit present);
      int unsigned gap;
      bit hrise, vrise, viol;
      gap = $urandom_range(3, 1);
      repeat (gap) begin
         @(negedge clk);
         exp_err = 0;
         exp_fs  = 0;
         chk_all();
      end
      i_px_clk    = 1'b1;
      i_vga_hsync = present && (p < HSW);
      i_vga_vsync = (l < VSW);
      @(negedge clk);
      i_px_clk = 1'b0;

      hrise = present && (p == 0);
      vrise = (l == 0) && (p == 0);
      viol  = 0;
      if (hrise) begin
         if (k != HT - 1) viol = 1;
         k = 0;
      end else begin
         k++;
         if (k == HT) viol = 1;
      end
      if (vrise) begin
         if (lidx != VT - 1) viol = 1;
         lidx = 0;
      end else if (hrise) begin
         lidx++;
         if (lidx == VT) viol = 1;
      end
      exp_fs  = vrise;
      exp_err = armed && viol;
      if (!armed) begin
         if (vrise) begin armed = 1; good = 0; end
      end else if (viol) begin
         locked = 0; good = 0; armed = vrise;
      end else if (vrise && !locked) begin
         good++;
         if (good == LF) locked = 1;
      end
      exp_locked = locked;
      exp_de = locked && (p >= HAS) && (p < HAS + HAL) && (l >= VAS) && (l < VAS + VAL);
      exp_x  = exp_de ? CB'(p - HAS) : '0;
      exp_y  = exp_de ? CB'(l - VAS) : '0;
      chk_all();
   endtask

   task automatic send_frame(input int n_lines, input int first, input int short_l, input int drop_l);
      for (int l = first; l < n_lines; l++) begin
         int len;
         len = (l == short_l) ? HT - 1 : HT;
         for (int p = 0; p < len; p++) pixel(l, p, l != drop_l);
      end
   endtask

   initial begin
      int sel;
      i_sclr = 1'b1; i_px_clk = 1'b0; i_vga_hsync = 1'b0; i_vga_vsync = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk_all();
      i_sclr = 1'b0;
      @(negedge clk);

      // ideal stream: lock at the third vsync edge
      send_frame(VT, 0, -1, -1);
      send_frame(VT, 0, -1, -1);
      chk("lock_after_2_frames", 32'(o_locked), 32'd0);
      send_frame(VT, 0, -1, -1);
      chk("lock_in_3rd_frame", 32'(o_locked), 32'd1);
      send_frame(VT, 0, -1, -1);

      // one short line, then relock
      sel = int'($urandom_range(VT - 2, VSW));
      send_frame(VT, 0, sel, -1);
      chk("unlock_short_line", 32'(o_locked), 32'd0);
      repeat (3) send_frame(VT, 0, -1, -1);
      chk("relock_short_line", 32'(o_locked), 32'd1);

      // one suppressed hsync, then relock
      sel = int'($urandom_range(VT - 2, VSW));
      send_frame(VT, 0, -1, sel);
      chk("unlock_drop_hsync", 32'(o_locked), 32'd0);
      repeat (3) send_frame(VT, 0, -1, -1);
      chk("relock_drop_hsync", 32'(o_locked), 32'd1);

      // short frame while checking
      send_frame(VT, 0, VSW + 1, -1);
      send_frame(VT, 0, -1, -1);
      send_frame(VT - 1, 0, -1, -1);
      repeat (2) send_frame(VT, 0, -1, -1);
      chk("no_lock_after_short_frame", 32'(o_locked), 32'd0);
      send_frame(VT, 0, -1, -1);
      chk("relock_short_frame", 32'(o_locked), 32'd1);

      // asynchronous reset mid-frame while locked
      send_frame(6, 0, -1, -1);
      for (int p = 0; p < 10; p++) pixel(6, p, 1'b1);
      chk("locked_before_reset", 32'(o_locked), 32'd1);
      @(negedge clk);
      #1 i_sclr = 1'b1;
      #1 model_reset();
      chk_all();
      repeat (3) @(negedge clk);
      i_sclr = 1'b0;
      repeat (100) begin
         @(negedge clk);
         chk_all();
      end
      send_frame(VT, 7, -1, -1);
      send_frame(VT, 0, -1, -1);
      send_frame(VT, 0, -1, -1);
      chk("no_lock_after_reset", 32'(o_locked), 32'd0);
      send_frame(VT, 0, -1, -1);
      chk("relock_after_reset", 32'(o_locked), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
